regfile_scanner: RTL and testbench
==================================

# regfile_scanner

Read-side companion to the Fibonacci write sequencer. It owns the register file's A read port and steps an index through registers 0–15, under push-button control or automatically. It captures the selected 16-bit value and shows it as four hex digits on the multiplexed seven-segment display. The write sequencer keeps sole use of the write port and B port.

## Interface
- TICK_DIV, 50000: Clock cycles per display refresh tick (≥2).
- AUTO_DIV, 250: Refresh ticks between automatic index advances (≥1).
- DEBOUNCE_CYCLES, 100000: Consecutive stable cycles required to accept a button level (≥1).
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low.
- Next  in  1  button, active-low, asynchronous to Clock; advances the index.
- Prev  in  1  button, active-low, asynchronous to Clock; retreats the index.
- AutoMode  in  1  switch; 1 = auto-advance.
- ReadData  in  16  register-file A-port data, combinational from ReadSelect.
- ReadSelect  out  4  register-file A-port select, registered.
- Value  out  16  last captured register value.
- Valid  out  1  high once Value holds data for the current ReadSelect.
- IndexLed  out  4  current index.
- Anodes  out  4  digit enables, active-low, one-hot; Anodes[0] is the rightmost digit.
- Segments  out  7  active-low, bit order {g,f,e,d,c,b,a}.

## Operation
- Reset values:
  - ReadSelect = 0, IndexLed = 0, Value = 0, Valid = 0.
  - Anodes = 4'b1110, Segments = 7'b1000000 (hex 0).
  - FSM in SELECT; all counters 0.
- Buttons:
  - Each button passes through a 2-flop synchronizer, then a debounce counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive equal samples.
  - A high→low transition of the accepted level produces a one-cycle step pulse.
- Index update:
  - Next pulse: index+1, wrapping 15→0.
  - Prev pulse: index−1, wrapping 0→15.
  - Next and Prev pulses in the same cycle: no change.
- FSM:
  - SELECT: ReadSelect ← index; Valid ← 0; go to CAPTURE.
  - CAPTURE: Value ← ReadData; Valid ← 1; go to HOLD.
  - HOLD, step pulse or auto-advance: update index, go to SELECT.
  - HOLD, refresh tick with no step: Value ← ReadData (live refresh of the same register), stay in HOLD.
  - HOLD, otherwise: stay in HOLD.
- Step events arriving in SELECT or CAPTURE are dropped.
- Auto-advance:
  - Counts refresh ticks while AutoMode = 1.
  - At AUTO_DIV ticks it acts as a Next pulse and the count clears.
  - A manual step pulse, or AutoMode = 0, clears the count.
- Display:
  - The refresh counter wraps at TICK_DIV−1 and emits one tick.
  - The digit counter advances 0→1→2→3→0 on each tick.
  - Digit d shows Value[4d+3:4d] with Anodes[d] = 0.
  - Segments is the combinational hex decode (0–F) of the selected nibble.

## Timing
- Step pulse seen in HOLD at cycle N:
  - SELECT at N+1; ReadSelect new at N+2.
  - CAPTURE at N+2; Value/Valid new at N+3.
- Valid is low for exactly one cycle (N+2) per index change.
- Button press latency to step pulse: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1.
- Reset assertion mid-operation returns every output to its reset value immediately, with no clock required.
- Reset release: first CAPTURE on the 2nd clock edge after release.

## Configuration
- REGSCAN_AUTO_EN defined: auto-advance logic is present and behaves as described.
- REGSCAN_AUTO_EN undefined: the auto-advance counter is not built, AutoMode is ignored, and the index changes only on button pulses.

## Structure
- Shared package regscan_pkg holds:
  - the FSM state enum (SELECT, CAPTURE, HOLD);
  - the 16-entry hex-to-segment constant table;
  - the digit count (4).
- Sub-module button_sync, instanced twice: synchronizer, debounce counter and falling-edge pulse; parameter DEBOUNCE_CYCLES.

## Test plan
Parameters: TICK_DIV=4, AUTO_DIV=3, DEBOUNCE_CYCLES=2; register model holds reg[i] = 16'h1000+i.
- Release Reset:
  - ReadSelect = 0; Value = 16'h1000 and Valid = 1 by the 2nd edge.
  - Anodes cycle 1110→1101→1011→0111 every 4 cycles.
  - Segments show 0, 0, 0, 1 on digits 0–3.
- Hold Next low 5 cycles:
  - Exactly one step; ReadSelect = 1, Value = 16'h1001.
  - A 1-cycle glitch on Next produces no step.
- Wrap:
  - Prev from index 0 → index 15, Value = 16'h100F.
  - Next from 15 → 0.
  - Next and Prev pressed together → index unchanged.
- AutoMode = 1 with the macro defined:
  - Index advances every 12 cycles.
  - A manual Next restarts the 12-cycle count.
  - With the macro undefined: no advance.
- Change reg[index] while in HOLD: Value follows within 4 cycles, and Valid stays 1.
- Assert Reset mid-CAPTURE: outputs return to reset values asynchronously, and the index restarts at 0.

Source files
------------

// File: rtl/regscan_pkg.sv
// ---------------------------------------------------------------------------
// regscan_pkg
// Shared definitions for the register-file read scanner:
//   - scanState_t : read-port sequencing states (SELECT, CAPTURE, HOLD)
//   - DIGIT_COUNT : number of multiplexed seven-segment digits
//   - HEX_TO_SEG  : active-low {g,f,e,d,c,b,a} patterns for hex 0..F
//   - hexToSeg()  : nibble to segment-pattern lookup
// ---------------------------------------------------------------------------
package regscan_pkg;

    typedef enum logic [1:0] {
        SELECT  = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } scanState_t;

    localparam int DIGIT_COUNT = 4;

    // A segment is lit when its bit is 0.
    localparam logic [6:0] HEX_TO_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hexToSeg(input logic [3:0] nibble);
        return HEX_TO_SEG[nibble];
    endfunction

endpackage

// File: rtl/button_sync.sv
// ---------------------------------------------------------------------------
// button_sync
// Conditions one active-low push button: a 2-flop synchronizer, a debounce
// counter and a falling-edge detector on the accepted level.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable samples needed to accept a level
// Ports:
//   Clock     in  system clock
//   Reset     in  asynchronous, active-low
//   ButtonN   in  raw button level, active-low, asynchronous to Clock
//   StepPulse out one-cycle pulse when the accepted level goes high->low
// ---------------------------------------------------------------------------
module button_sync #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic ButtonN,
    output logic StepPulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          syncStage1;
    logic          syncStage2;
    logic          acceptedLevel;
    logic          lastAccepted;
    logic [CW-1:0] stableCount;

    // Two-flop synchronizer; idles high because the button is active-low.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            syncStage1 <= 1'b1;
            syncStage2 <= 1'b1;
        end else begin
            syncStage1 <= ButtonN;
            syncStage2 <= syncStage1;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample restarts the count, so a bounce never gets through.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stableCount   <= '0;
            acceptedLevel <= 1'b1;
        end else if (syncStage2 == acceptedLevel) begin
            stableCount <= '0;
        end else if (stableCount == CW'(DEBOUNCE_CYCLES - 1)) begin
            acceptedLevel <= syncStage2;
            stableCount   <= '0;
        end else begin
            stableCount <= stableCount + 1'b1;
        end
    end

    // Registered falling-edge detect gives exactly one pulse per press.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            lastAccepted <= 1'b1;
            StepPulse    <= 1'b0;
        end else begin
            lastAccepted <= acceptedLevel;
            StepPulse    <= lastAccepted & ~acceptedLevel;
        end
    end

endmodule

// File: rtl/regfile_scanner.sv
// ---------------------------------------------------------------------------
// regfile_scanner
// Steps an index through registers 0..15 on the register file's A read port,
// captures the selected value and shows it as four hex digits on a
// multiplexed seven-segment display.
//
// Build option:
//   REGSCAN_AUTO_EN : when defined, AutoMode advances the index every
//                     AUTO_DIV refresh ticks; otherwise AutoMode is ignored.
// Parameters:
//   TICK_DIV        : clock cycles per display refresh tick (>=2)
//   AUTO_DIV        : refresh ticks per automatic advance (>=1)
//   DEBOUNCE_CYCLES : stable cycles needed to accept a button level (>=1)
// Ports:
//   Clock      in   system clock
//   Reset      in   asynchronous, active-low
//   Next       in   button, active-low; advances the index
//   Prev       in   button, active-low; retreats the index
//   AutoMode   in   1 = auto-advance
//   ReadData   in   [15:0] A-port data, combinational from ReadSelect
//   ReadSelect out  [3:0]  A-port select, registered
//   Value      out  [15:0] last captured register value
//   Valid      out  high once Value holds data for the current ReadSelect
//   IndexLed   out  [3:0]  current index
//   Anodes     out  [3:0]  digit enables, active-low, one-hot
//   Segments   out  [6:0]  active-low {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module regfile_scanner
    import regscan_pkg::*;
#(
    parameter int TICK_DIV        = 50000,
    parameter int AUTO_DIV        = 250,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Next,
    input  logic        Prev,
    input  logic        AutoMode,
    input  logic [15:0] ReadData,
    output logic [3:0]  ReadSelect,
    output logic [15:0] Value,
    output logic        Valid,
    output logic [3:0]  IndexLed,
    output logic [3:0]  Anodes,
    output logic [6:0]  Segments
);

    localparam int RW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DIGIT_COUNT);

    scanState_t    state;
    logic [3:0]    index;
    logic [RW-1:0] refreshCount;
    logic [DW-1:0] digit;
    logic          refreshTick;
    logic          nextPulse;
    logic          prevPulse;
    logic          manualStep;
    logic          autoFire;
    logic          stepNext;
    logic          stepPrev;

    button_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) nextSync (
        .Clock     (Clock),
        .Reset     (Reset),
        .ButtonN   (Next),
        .StepPulse (nextPulse)
    );

    button_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) prevSync (
        .Clock     (Clock),
        .Reset     (Reset),
        .ButtonN   (Prev),
        .StepPulse (prevPulse)
    );

    assign manualStep  = nextPulse | prevPulse;
    assign refreshTick = (refreshCount == RW'(TICK_DIV - 1));

    // Refresh timebase and digit scan; the digit moves on every tick.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            refreshCount <= '0;
            digit        <= '0;
        end else if (refreshTick) begin
            refreshCount <= '0;
            digit        <= digit + 1'b1;
        end else begin
            refreshCount <= refreshCount + 1'b1;
        end
    end

`ifdef REGSCAN_AUTO_EN
    localparam int AW = $clog2(AUTO_DIV + 1);

    logic [AW-1:0] autoCount;

    assign autoFire = AutoMode && !manualStep && refreshTick
                      && (autoCount == AW'(AUTO_DIV - 1));

    // Counts refresh ticks while auto mode is on. A manual press restarts
    // the interval so the user always gets a full period after stepping.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            autoCount <= '0;
        end else if (!AutoMode || manualStep) begin
            autoCount <= '0;
        end else if (refreshTick) begin
            if (autoCount == AW'(AUTO_DIV - 1)) begin
                autoCount <= '0;
            end else begin
                autoCount <= autoCount + 1'b1;
            end
        end
    end
`else
    // AutoMode has no effect in this build; the AND keeps the port used.
    assign autoFire = AutoMode & 1'b0;
`endif

    // An auto-advance behaves exactly like a Next press.
    assign stepNext = nextPulse | autoFire;
    assign stepPrev = prevPulse;

    // Read sequencing: present the select, capture the data a cycle later,
    // then hold and refresh the same register until the index moves. Steps
    // that arrive outside HOLD are dropped.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= SELECT;
            index      <= 4'd0;
            ReadSelect <= 4'd0;
            Value      <= 16'd0;
            Valid      <= 1'b0;
        end else begin
            case (state)
                SELECT: begin
                    ReadSelect <= index;
                    Valid      <= 1'b0;
                    state      <= CAPTURE;
                end
                CAPTURE: begin
                    Value <= ReadData;
                    Valid <= 1'b1;
                    state <= HOLD;
                end
                HOLD: begin
                    if (stepNext || stepPrev) begin
                        if (stepNext && !stepPrev) begin
                            index <= index + 4'd1;
                        end else if (stepPrev && !stepNext) begin
                            index <= index - 4'd1;
                        end
                        state <= SELECT;
                    end else if (refreshTick) begin
                        Value <= ReadData;
                    end
                end
                default: begin
                    state <= SELECT;
                end
            endcase
        end
    end

    assign IndexLed = index;
    assign Anodes   = ~(4'b0001 << digit);
    assign Segments = hexToSeg(Value[4*digit +: 4]);

endmodule

// File: tb/tb_regfile_scanner.sv
// ---------------------------------------------------------------------------
// tb_regfile_scanner
// Self-checking bench for regfile_scanner with TICK_DIV=4, AUTO_DIV=3,
// DEBOUNCE_CYCLES=2 and a register model holding reg[i] = 16'h1000 + i.
// The expected index, value and display are derived from a simple model:
// an index taken modulo 16, an array of register contents and the elapsed
// clock count since reset release.
// ---------------------------------------------------------------------------
module tb_regfile_scanner;

    localparam int TICK_DIV = 4;
    localparam int AUTO_DIV = 3;
    localparam int DEB      = 2;

    logic        Clock    = 1'b0;
    logic        Reset    = 1'b1;
    logic        Next     = 1'b1;
    logic        Prev     = 1'b1;
    logic        AutoMode = 1'b0;
    logic [15:0] ReadData;
    logic [3:0]  ReadSelect;
    logic [15:0] Value;
    logic        Valid;
    logic [3:0]  IndexLed;
    logic [3:0]  Anodes;
    logic [6:0]  Segments;

    logic [15:0] regs [16];
    int          checkCount = 0;
    int          errorCount = 0;
    int          modelIndex = 0;
    int          edgeCount;

    regfile_scanner #(
        .TICK_DIV        (TICK_DIV),
        .AUTO_DIV        (AUTO_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Next       (Next),
        .Prev       (Prev),
        .AutoMode   (AutoMode),
        .ReadData   (ReadData),
        .ReadSelect (ReadSelect),
        .Value      (Value),
        .Valid      (Valid),
        .IndexLed   (IndexLed),
        .Anodes     (Anodes),
        .Segments   (Segments)
    );

    always #5 Clock = ~Clock;

    // Register file A port is combinational from the select.
    assign ReadData = regs[ReadSelect];

    // Clock edges since reset release, the timebase for the display model.
    always @(posedge Clock or negedge Reset) begin
        if (!Reset) edgeCount <= 0;
        else        edgeCount <= edgeCount + 1;
    end

    function automatic logic [6:0] segFor(input logic [3:0] n);
        case (n)
            4'h0: segFor = 7'h40; 4'h1: segFor = 7'h79;
            4'h2: segFor = 7'h24; 4'h3: segFor = 7'h30;
            4'h4: segFor = 7'h19; 4'h5: segFor = 7'h12;
            4'h6: segFor = 7'h02; 4'h7: segFor = 7'h78;
            4'h8: segFor = 7'h00; 4'h9: segFor = 7'h10;
            4'hA: segFor = 7'h08; 4'hB: segFor = 7'h03;
            4'hC: segFor = 7'h46; 4'hD: segFor = 7'h21;
            4'hE: segFor = 7'h06; default: segFor = 7'h0E;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Drive the selected buttons low for lowCycles, then release them.
    task automatic applyStimulus(input logic nextLow, input logic prevLow,
                                 input int lowCycles);
        @(negedge Clock);
        Next = ~nextLow;
        Prev = ~prevLow;
        waitCycles(lowCycles);
        Next = 1'b1;
        Prev = 1'b1;
    endtask

    task automatic checkSettled(input string tag);
        checkOutput({tag, ".index"},  32'(IndexLed),   32'(modelIndex));
        checkOutput({tag, ".select"}, 32'(ReadSelect), 32'(modelIndex));
        checkOutput({tag, ".value"},  32'(Value),      32'(regs[modelIndex]));
        checkOutput({tag, ".valid"},  32'(Valid),      32'd1);
    endtask

    task automatic checkDisplay(input string tag);
        int          d;
        logic [15:0] v;
        d = (edgeCount / TICK_DIV) % 4;
        v = regs[modelIndex];
        checkOutput({tag, ".anodes"}, 32'(Anodes), 32'(4'hF & ~(4'b0001 << d)));
        checkOutput({tag, ".segs"},   32'(Segments), 32'(segFor(v[4*d +: 4])));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".select"}, 32'(ReadSelect), 32'd0);
        checkOutput({tag, ".index"},  32'(IndexLed),   32'd0);
        checkOutput({tag, ".value"},  32'(Value),      32'd0);
        checkOutput({tag, ".valid"},  32'(Valid),      32'd0);
        checkOutput({tag, ".anodes"}, 32'(Anodes),     32'hE);
        checkOutput({tag, ".segs"},   32'(Segments),   32'h40);
    endtask

    initial begin
        int          validLow;
        int          op;
        int          idx;
        int          nChanges;
        int          changeAt [3];
        int          manualAt;
        int          autoAt;
        logic [3:0]  lastLed;

        for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);

        // Reset and release; first capture lands on the second edge.
        #2 Reset = 1'b0;
        #10;
        checkResetValues("reset");
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        checkOutput("release.edge1Valid", 32'(Valid), 32'd0);
        @(negedge Clock);
        checkOutput("release.edge2Valid", 32'(Valid), 32'd1);
        checkOutput("release.edge2Value", 32'(Value), 32'h1000);
        checkOutput("release.select",     32'(ReadSelect), 32'd0);

        for (int k = 0; k < 16; k++) begin
            checkDisplay("scan");
            @(negedge Clock);
        end

        // One held Next press with exact step timing.
        Next = 1'b0;
        validLow = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge Clock);
            if (k == 5) Next = 1'b1;
            if (Valid == 1'b0) validLow++;
            if (k == 5) checkOutput("step.indexOld",  32'(IndexLed),   32'd0);
            if (k == 6) checkOutput("step.indexNew",  32'(IndexLed),   32'd1);
            if (k == 6) checkOutput("step.selectOld", 32'(ReadSelect), 32'd0);
            if (k == 7) checkOutput("step.selectNew", 32'(ReadSelect), 32'd1);
            if (k == 7) checkOutput("step.validLow",  32'(Valid),      32'd0);
            if (k == 8) checkOutput("step.valueNew",  32'(Value),      32'h1001);
        end
        checkOutput("step.validLowCycles", 32'(validLow), 32'd1);
        modelIndex = 1;
        waitCycles(10);
        checkSettled("oneStep");

        // A single-cycle glitch is filtered out.
        applyStimulus(1'b1, 1'b0, 1);
        waitCycles(12);
        checkSettled("glitch");

        // Wrap in both directions, then simultaneous presses.
        applyStimulus(1'b0, 1'b1, 5); waitCycles(12);
        modelIndex = 0;  checkSettled("prevTo0");
        applyStimulus(1'b0, 1'b1, 5); waitCycles(12);
        modelIndex = 15; checkSettled("wrapDown");
        applyStimulus(1'b1, 1'b0, 5); waitCycles(12);
        modelIndex = 0;  checkSettled("wrapUp");
        applyStimulus(1'b1, 1'b1, 5); waitCycles(12);
        checkSettled("both");

        // Randomized presses, glitches and register writes.
        for (int n = 0; n < 24; n++) begin
            op = int'($urandom_range(0, 4));
            case (op)
                0: begin
                    applyStimulus(1'b1, 1'b0, int'($urandom_range(4, 7)));
                    modelIndex = (modelIndex + 1) % 16;
                end
                1: begin
                    applyStimulus(1'b0, 1'b1, int'($urandom_range(4, 7)));
                    modelIndex = (modelIndex + 15) % 16;
                end
                2: applyStimulus(1'b1, 1'b1, int'($urandom_range(4, 7)));
                3: applyStimulus(1'b1, 1'b0, 1);
                default: begin
                    idx = (n % 3 == 0) ? modelIndex : int'($urandom_range(0, 15));
                    regs[idx] = 16'($urandom);
                    if (idx == modelIndex) begin
                        for (int k = 1; k <= 4; k++) begin
                            @(negedge Clock);
                            checkOutput("live.valid", 32'(Valid), 32'd1);
                        end
                        checkOutput("live.value", 32'(Value), 32'(regs[idx]));
                    end
                end
            endcase
            waitCycles(12);
            checkSettled("random");
        end
        checkDisplay("randomDisplay");

`ifdef REGSCAN_AUTO_EN
        // Auto-advance every AUTO_DIV*TICK_DIV cycles.
        AutoMode = 1'b1;
        lastLed  = IndexLed;
        nChanges = 0;
        for (int k = 0; k < 80 && nChanges < 3; k++) begin
            @(negedge Clock);
            if (IndexLed !== lastLed) begin
                changeAt[nChanges] = edgeCount;
                nChanges++;
                modelIndex = (modelIndex + 1) % 16;
                checkOutput("auto.index", 32'(IndexLed), 32'(modelIndex));
                lastLed = IndexLed;
            end
        end
        checkOutput("auto.changes", 32'(nChanges), 32'd3);
        if (nChanges == 3) begin
            checkOutput("auto.gap1", 32'(changeAt[1] - changeAt[0]), 32'd12);
            checkOutput("auto.gap2", 32'(changeAt[2] - changeAt[1]), 32'd12);
        end

        // A manual Next right after an auto step restarts the interval.
        Next     = 1'b0;
        manualAt = -1;
        autoAt   = -1;
        for (int k = 1; k <= 40 && autoAt < 0; k++) begin
            @(negedge Clock);
            if (k == 5) Next = 1'b1;
            if (IndexLed !== lastLed) begin
                if (manualAt < 0) manualAt = edgeCount;
                else              autoAt   = edgeCount;
                modelIndex = (modelIndex + 1) % 16;
                lastLed = IndexLed;
            end
        end
        Next = 1'b1;
        checkOutput("autoRestart.seen", 32'(autoAt >= 0 && manualAt >= 0), 32'd1);
        checkOutput("autoRestart.gap",
                    32'((autoAt - manualAt) >= 9 && (autoAt - manualAt) <= 12), 32'd1);
        AutoMode = 1'b0;
        waitCycles(12);
        checkSettled("autoOff");
`else
        AutoMode = 1'b1;
        waitCycles(40);
        checkSettled("autoIgnored");
        AutoMode = 1'b0;
`endif

        // Reset asserted while in CAPTURE clears everything immediately.
        waitCycles(4);
        Next = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge Clock);
            if (k == 5) Next = 1'b1;
        end
        Reset = 1'b0;
        #1;
        checkResetValues("midReset");
        Next = 1'b1;
        waitCycles(2);
        Reset = 1'b1;
        modelIndex = 0;
        waitCycles(2);
        checkSettled("afterReset");
        checkOutput("afterReset.value", 32'(Value), 32'(regs[0]));

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
